rom_word_byte_writer: RTL

- Upstream loader stage for the game core's ROM download port.
- Takes 32-bit word writes from the bridge ROM bus, already moved into the core clock domain, and buffers them in a small FIFO.
- Replays each word as four byte writes (address, strobe, data) on a 25-bit address / 8-bit data port, paced by a fixed cycle spacing.
- Sits between the bridge CDC and the core's ioctl_addr/ioctl_wr/ioctl_data inputs; replaces a fixed-rate unpacker with one that tolerates bursts.

---
 rtl/rom_word_byte_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rom_word_byte_writer.sv
// rtl/rom_word_byte_writer.sv - buffers 32-bit ROM words and replays them as paced byte writes
module rom_word_byte_writer #(
    parameter int CYCLES     = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [31:0]           addr,
    input  logic [31:0]           wr_data,
    output logic                  byte_wr,
    output logic [ADDR_WIDTH-1:0] byte_addr,
    output logic [7:0]            byte_data,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = ADDR_WIDTH - 2;
    localparam int EW = WW + 32;
    localparam logic [7:0] CNT_RELOAD = 8'(CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, GAP} state_t;

    logic [EW-1:0]         r_mem [DEPTH];
    logic [PW:0]           r_wptr, r_rptr;
    logic [WW-1:0]         r_word_addr;
    logic [31:0]           r_word_data;
    state_t                r_state, w_state_next;
    logic [7:0]            r_cnt, w_cnt_next;
    logic [1:0]            r_idx, w_idx_next;
    logic                  r_byte_wr, r_busy, r_overflow;
    logic [ADDR_WIDTH-1:0] r_byte_addr;
    logic [7:0]            r_byte_data, w_byte;
    logic                  w_empty, w_full, w_pop, w_push, w_drop, w_emit;
    logic [PW:0]           w_wptr_next, w_rptr_next;
    logic                  w_unused;

    assign w_unused    = ^{addr[31:ADDR_WIDTH], addr[1:0]};
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop       = (r_state == IDLE) && !w_empty;
    // A full FIFO still takes a word when the slot is freed on the same edge.
    assign w_push      = wr && (!w_full || w_pop);
    assign w_drop      = wr && !w_push;
    assign w_wptr_next = r_wptr + (PW + 1)'(w_push);
    assign w_rptr_next = r_rptr + (PW + 1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= {addr[ADDR_WIDTH-1:2], wr_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word_addr <= '0;
            r_word_data <= '0;
            r_byte_wr   <= 1'b0;
            r_byte_addr <= '0;
            r_byte_data <= '0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wptr    <= w_wptr_next;
            r_rptr    <= w_rptr_next;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_byte_wr <= w_emit;
            r_busy    <= (w_wptr_next != w_rptr_next) || (w_state_next != IDLE);
            if (w_pop) {r_word_addr, r_word_data} <= r_mem[r_rptr[PW-1:0]];
            if (w_emit) begin
                r_byte_addr <= {r_word_addr, r_idx};
                r_byte_data <= w_byte;
            end
            if (w_drop)            r_overflow <= 1'b1;
            else if (overflow_clr) r_overflow <= 1'b0;
        end
    end

    // Big-endian: byte 0 is the most significant byte of the word.
    always_comb begin
        w_byte = r_word_data[31:24];
        case (r_idx)
            2'd1:    w_byte = r_word_data[23:16];
            2'd2:    w_byte = r_word_data[15:8];
            2'd3:    w_byte = r_word_data[7:0];
            default: w_byte = r_word_data[31:24];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_emit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_idx_next   = 2'd0;
                    w_state_next = LOAD;
                end
            end
            LOAD: w_state_next = EMIT;
            EMIT: begin
                w_emit     = 1'b1;
                w_cnt_next = CNT_RELOAD;
                if (CNT_RELOAD == 8'd0) begin
                    if (r_idx == 2'd3) w_state_next = IDLE;
                    else               w_idx_next   = r_idx + 2'd1;
                end else begin
                    w_state_next = GAP;
                end
            end
            GAP: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_cnt_next = 8'd0;
                    if (r_idx == 2'd3) begin
                        w_state_next = IDLE;
                    end else begin
                        w_idx_next   = r_idx + 2'd1;
                        w_state_next = EMIT;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign byte_wr   = r_byte_wr;
    assign byte_addr = r_byte_addr;
    assign byte_data = r_byte_data;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
endmodule
